count_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 16-bit loadable up-counter (load/inc/d/q datapath)

---
 rtl/count_share_arb_if.sv | 40 ++++
 rtl/count_share_arb.sv | 169 ++++++++++++++++
 tb/tb_count_share_arb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_share_arb_if.sv
// Core-side and counter-side signal bundle for count_share_arb.
// COUNT_SHARE_SAT_EN adds the sat completion flag.
interface count_share_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rdata;
  logic              busy;
  logic [W-1:0]      cnt_q;
  logic [W-1:0]      cnt_d;
  logic              cnt_load;
  logic              cnt_inc;
`ifdef COUNT_SHARE_SAT_EN
  logic              sat;

  modport master (
    output req, op, wdata, cnt_q,
    input  ack, rdata, busy, cnt_d, cnt_load, cnt_inc, sat
  );

  modport slave (
    input  req, op, wdata, cnt_q,
    output ack, rdata, busy, cnt_d, cnt_load, cnt_inc, sat
  );
`else
  modport master (
    output req, op, wdata, cnt_q,
    input  ack, rdata, busy, cnt_d, cnt_load, cnt_inc
  );

  modport slave (
    input  req, op, wdata, cnt_q,
    output ack, rdata, busy, cnt_d, cnt_load, cnt_inc
  );
`endif
endinterface

// File: rtl/count_share_arb.sv
// Round-robin sequencer sharing one loadable up-counter between NREQ cores (READ/FETCH-INC/SWAP).
// Define COUNT_SHARE_SAT_EN to make FETCH-INC saturate at all-ones and flag it on sat.
module count_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input logic              CLK,
  input logic              RST,
  count_share_arb_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
  typedef enum logic [1:0] {OpRead = 2'b00, OpFinc = 2'b01, OpSwap = 2'b10, OpRead3 = 2'b11} op_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic [W-1:0]    cnt_d_q, cnt_d_d;
  logic            busy_q, busy_d;
  logic            load_q, load_d;
  logic            inc_q, inc_d;
`ifdef COUNT_SHARE_SAT_EN
  logic            sat_pend_q, sat_pend_d;
  logic            sat_q, sat_d;
`endif

  // Per-core views of the packed opcode and write-data buses
  logic [1:0]   op_arr [NREQ];
  logic [W-1:0] wd_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = bus.op[2*i +: 2];
    assign wd_arr[i] = bus.wdata[W*i +: W];
  end

  // First requester at or after rr_ptr, wrapping modulo NREQ
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] scan_idx;
  int unsigned   scan;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan     = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan     = (32'(rr_ptr_q) + i) % NREQ;
      scan_idx = IW'(scan);
      if (!gnt_vld && bus.req[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  op_e gnt_op;
  assign gnt_op = op_e'(op_arr[gnt_idx]);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    cnt_d_d  = cnt_d_q;
    busy_d   = busy_q;
    load_d   = 1'b0;
    inc_d    = 1'b0;
`ifdef COUNT_SHARE_SAT_EN
    sat_pend_d = sat_pend_q;
    sat_d      = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          state_d = StIssue;
          busy_d  = 1'b1;
          gnt_d   = gnt_idx;
`ifdef COUNT_SHARE_SAT_EN
          sat_pend_d = 1'b0;
`endif
          // Strobes are registered, so they are decided here to be live for all of ISSUE.
          // Only this block moves the counter, so cnt_q here equals cnt_q during ISSUE.
          case (gnt_op)
            OpFinc: begin
`ifdef COUNT_SHARE_SAT_EN
              if (bus.cnt_q == {W{1'b1}}) begin
                sat_pend_d = 1'b1;
              end else begin
                inc_d = 1'b1;
              end
`else
              inc_d = 1'b1;
`endif
            end
            OpSwap: begin
              load_d  = 1'b1;
              cnt_d_d = wd_arr[gnt_idx];
            end
            default: ;
          endcase
        end
      end
      StIssue: begin
        state_d        = StResp;
        ack_d[gnt_q]   = 1'b1;
        rdata_d        = bus.cnt_q;
`ifdef COUNT_SHARE_SAT_EN
        sat_d = sat_pend_q;
`endif
      end
      StResp: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      cnt_d_q  <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
`ifdef COUNT_SHARE_SAT_EN
      sat_pend_q <= 1'b0;
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      cnt_d_q  <= cnt_d_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
`ifdef COUNT_SHARE_SAT_EN
      sat_pend_q <= sat_pend_d;
      sat_q      <= sat_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.cnt_d    = cnt_d_q;
  assign bus.cnt_load = load_q;
  assign bus.cnt_inc  = inc_q;
`ifdef COUNT_SHARE_SAT_EN
  assign bus.sat      = sat_q;
`endif

endmodule

// File: tb/tb_count_share_arb.sv
// Scoreboard bench for count_share_arb with a behavioural load/inc counter attached.
// Honours COUNT_SHARE_SAT_EN the same way as the design.
module tb_count_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  count_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  count_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Counter under arbitration; force_en lets the bench preset it
  logic [W-1:0] cnt;
  logic         force_en  = 1'b0;
  logic [W-1:0] force_val = '0;

  always @(posedge CLK) begin
    if (force_en)          cnt <= force_val;
    else if (bus.cnt_load) cnt <= bus.cnt_d;
    else if (bus.cnt_inc)  cnt <= cnt + 1'b1;
  end
  assign bus.cnt_q = cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           core;
    logic [W-1:0] data;
    logic         sat;
  } exp_t;

  exp_t sbq[$];

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if (bus.cnt_load && bus.cnt_inc) begin
        errors++;
        $display("FAIL strobe_excl load=%b inc=%b required not both high", bus.cnt_load,
                 bus.cnt_inc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic set_cnt(input logic [W-1:0] v);
    force_en  = 1'b1;
    force_val = v;
    @(negedge CLK);
    force_en  = 1'b0;
  endtask

  task automatic wait_ack(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      cyc++;
      if (bus.ack != '0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t            e;
    bit              got;
    int              cyc;
    logic [NREQ-1:0] exp_ack;
    RST       = 1'b1;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    set_cnt(16'h0050);
    @(negedge CLK);
    checks++;
    if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack got %h want 0", bus.ack); end
    checks++;
    if (bus.rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
    checks++;
    if ({bus.busy, bus.cnt_load, bus.cnt_inc} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags busy/load/inc got %b want 000",
               {bus.busy, bus.cnt_load, bus.cnt_inc});
    end
    checks++;
    if (bus.cnt_d !== '0) begin errors++; $display("FAIL reset_cnt_d got %h want 0", bus.cnt_d); end
`ifdef COUNT_SHARE_SAT_EN
    checks++;
    if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", bus.sat); end
`endif
    RST = 1'b0;
    // Cores 0 and 2 READ together: core 0 must win first after reset
    bus.req = 4'b0101;
    sbq.push_back('{0, 16'h0050, 1'b0});
    sbq.push_back('{2, 16'h0050, 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_ack(got, cyc);
      checks++;
      if (!got || sbq.size() == 0) begin
        errors++;
        $display("FAIL reset_grant_ack got none want ack #%0d", k);
      end else begin
        e = sbq.pop_front();
        exp_ack = '0;
        exp_ack[e.core] = 1'b1;
        if (bus.ack !== exp_ack || bus.rdata !== e.data) begin
          errors++;
          $display("FAIL reset_grant ack=%b rdata=%h want ack=%b rdata=%h", bus.ack, bus.rdata,
                   exp_ack, e.data);
        end
        bus.req = bus.req & ~bus.ack;
      end
    end
  endtask

  task automatic test_fetch_inc();
    exp_t e;
    set_cnt(16'h0010);
    bus.op[5:4] = 2'b01;
    bus.req     = 4'b0100;
    sbq.push_back('{2, 16'h0010, 1'b0});
    @(negedge CLK);
    checks++;
    if ({bus.cnt_inc, bus.cnt_load, bus.busy, bus.ack} !== {3'b101, 4'b0000}) begin
      errors++;
      $display("FAIL finc_issue inc/load/busy/ack got %b%b%b %b want 101 0000", bus.cnt_inc,
               bus.cnt_load, bus.busy, bus.ack);
    end
    @(negedge CLK);
    e = sbq.pop_front();
    checks++;
    if (bus.ack !== 4'b0100 || bus.rdata !== e.data) begin
      errors++;
      $display("FAIL finc_resp ack=%b rdata=%h want ack=0100 rdata=%h", bus.ack, bus.rdata,
               e.data);
    end
    checks++;
    if (cnt !== 16'h0011 || bus.cnt_inc !== 1'b0) begin
      errors++;
      $display("FAIL finc_counter cnt=%h inc=%b want cnt=0011 inc=0", cnt, bus.cnt_inc);
    end
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    exp_t            e;
    bit              got;
    int              cyc;
    logic [NREQ-1:0] exp_ack;
    int              order[6] = '{0, 1, 3, 0, 1, 3};
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    set_cnt(16'h0100);
    bus.op  = 8'b01_01_01_01;
    bus.req = 4'b1011;
    for (int k = 0; k < 6; k++) sbq.push_back('{order[k], 16'(16'h0100 + k), 1'b0});
    for (int k = 0; k < 6; k++) begin
      wait_ack(got, cyc);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rr_ack got none want ack #%0d", k);
        break;
      end
      e = sbq.pop_front();
      exp_ack = '0;
      exp_ack[e.core] = 1'b1;
      if (bus.ack !== exp_ack || bus.rdata !== e.data) begin
        errors++;
        $display("FAIL rr_order ack=%b rdata=%h want ack=%b rdata=%h", bus.ack, bus.rdata,
                 exp_ack, e.data);
      end
      checks++;
      if (cyc != ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL rr_gap cycles=%0d want %0d", cyc, (k == 0) ? 2 : 3);
      end
    end
    bus.req = '0;
    @(negedge CLK);
    checks++;
    if (cnt !== 16'h0106) begin errors++; $display("FAIL rr_count cnt=%h want 0106", cnt); end
  endtask

  task automatic test_swap();
    exp_t e;
    set_cnt(16'h1234);
    bus.op           = '0;
    bus.op[3:2]      = 2'b10;
    bus.wdata[31:16] = 16'hBEEF;
    bus.req          = 4'b0010;
    sbq.push_back('{1, 16'h1234, 1'b0});
    @(negedge CLK);
    checks++;
    if (bus.cnt_load !== 1'b1 || bus.cnt_inc !== 1'b0 || bus.cnt_d !== 16'hBEEF) begin
      errors++;
      $display("FAIL swap_issue load=%b inc=%b cnt_d=%h want 1 0 BEEF", bus.cnt_load,
               bus.cnt_inc, bus.cnt_d);
    end
    @(negedge CLK);
    e = sbq.pop_front();
    checks++;
    if (bus.ack !== 4'b0010 || bus.rdata !== e.data || cnt !== 16'hBEEF) begin
      errors++;
      $display("FAIL swap_resp ack=%b rdata=%h cnt=%h want 0010 %h BEEF", bus.ack, bus.rdata,
               cnt, e.data);
    end
    bus.req = '0;
    @(negedge CLK);
    checks++;
    if (bus.cnt_load !== 1'b0 || bus.cnt_d !== 16'hBEEF) begin
      errors++;
      $display("FAIL swap_hold load=%b cnt_d=%h want 0 BEEF", bus.cnt_load, bus.cnt_d);
    end
  endtask

  task automatic test_wrap();
    exp_t         e;
    logic         exp_inc;
    logic [W-1:0] exp_cnt;
`ifdef COUNT_SHARE_SAT_EN
    exp_inc = 1'b0;
    exp_cnt = 16'hFFFF;
    sbq.push_back('{2, 16'hFFFF, 1'b1});
`else
    exp_inc = 1'b1;
    exp_cnt = 16'h0000;
    sbq.push_back('{2, 16'hFFFF, 1'b0});
`endif
    set_cnt(16'hFFFF);
    bus.op      = '0;
    bus.op[5:4] = 2'b01;
    bus.req     = 4'b0100;
    @(negedge CLK);
    checks++;
    if (bus.cnt_inc !== exp_inc) begin
      errors++;
      $display("FAIL wrap_issue inc=%b want %b", bus.cnt_inc, exp_inc);
    end
    @(negedge CLK);
    e = sbq.pop_front();
    checks++;
    if (bus.ack !== 4'b0100 || bus.rdata !== e.data || cnt !== exp_cnt) begin
      errors++;
      $display("FAIL wrap_resp ack=%b rdata=%h cnt=%h want 0100 %h %h", bus.ack, bus.rdata,
               cnt, e.data, exp_cnt);
    end
`ifdef COUNT_SHARE_SAT_EN
    checks++;
    if (bus.sat !== e.sat) begin errors++; $display("FAIL wrap_sat got %b want %b", bus.sat, e.sat); end
`endif
    bus.req = '0;
  endtask

  task automatic test_rst_mid_op();
    exp_t            e;
    bit              got;
    int              cyc;
    logic [NREQ-1:0] exp_ack;
    // Pointer is 3 here, so core 3 is granted; after the abort core 1 must go first
    @(negedge CLK);
    bus.op  = '0;
    bus.req = 4'b1010;
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", bus.busy); end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ack !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort ack=%b busy=%b want 0000 0", bus.ack, bus.busy);
    end
    RST = 1'b0;
    sbq.push_back('{1, cnt, 1'b0});
    sbq.push_back('{3, cnt, 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_ack(got, cyc);
      checks++;
      if (!got || sbq.size() == 0) begin
        errors++;
        $display("FAIL rst_regrant got none want ack #%0d", k);
      end else begin
        e = sbq.pop_front();
        exp_ack = '0;
        exp_ack[e.core] = 1'b1;
        if (bus.ack !== exp_ack || bus.rdata !== e.data) begin
          errors++;
          $display("FAIL rst_regrant ack=%b rdata=%h want ack=%b rdata=%h", bus.ack, bus.rdata,
                   exp_ack, e.data);
        end
        bus.req = bus.req & ~bus.ack;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_inc();
    test_round_robin();
    test_swap();
    test_wrap();
    test_rst_mid_op();
    repeat (3) @(negedge CLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
